// File: rtl/prm_pkg.sv
// Shared constants, state types and the command-nibble encoder
// for the PRM relay-board bus master.
package prm_pkg;

  localparam logic [1:0] A_COM_LO = 2'd0;
  localparam logic [1:0] A_COM_HI = 2'd1;
  localparam logic [1:0] A_IND    = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  localparam logic [7:0] ENABLE_CODE = 8'hE1;

  typedef enum logic [2:0] {
    S_W0 = 3'd0,
    S_W1 = 3'd1,
    S_W2 = 3'd2,
    S_W3 = 3'd3,
    S_R3 = 3'd4,
    S_R1 = 3'd5
  } step_t;

  typedef enum logic [1:0] {
    AS_IDLE   = 2'd0,
    AS_SETUP  = 2'd1,
    AS_STROBE = 2'd2,
    AS_HOLD   = 2'd3
  } acc_state_t;

  // Each nibble is followed by its complement so the board can reject corrupted writes.
  function automatic logic [15:0] nib_enc(input logic [7:0] b);
    return {b[7:4], ~b[7:4], b[3:0], ~b[3:0]};
  endfunction

endpackage

// File: rtl/prm_bus_master_if.sv
// Backplane bus of the PRM relay-output board: data, strobes (active low),
// address and chip-select.
interface prm_bus_master_if;
  logic [15:0] oD;
  logic        oDOe;
  logic [15:0] iD;
  logic [1:0]  oA;
  logic [3:0]  oCS;
  logic        oRd;
  logic        oWr;

  modport master (output oD, oDOe, oA, oCS, oRd, oWr, input iD);
  modport slave  (input oD, oDOe, oA, oCS, oRd, oWr, output iD);
endinterface

// File: rtl/prm_bus_cycle.sv
// Single-access engine: SETUP/STROBE/HOLD timing, strobe generation and read capture.
// Chains directly from HOLD into the next SETUP while the sequencer has more steps.
module prm_bus_cycle
  import prm_pkg::*;
#(
  parameter logic [3:0]  CS      = 4'b0111,
  parameter logic [3:0]  CS_IDLE = 4'b1111,
  parameter int unsigned T_SU    = 2,
  parameter int unsigned T_STB   = 4,
  parameter int unsigned T_HLD   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        more,
  input  logic        wr,
  input  logic [1:0]  addr,
  input  logic [15:0] wdata,
  output logic        hold_end,
  output logic        rd_vld,
  output logic [15:0] rdata,
  output logic        done,
  prm_bus_master_if.master bus
);

  localparam logic [7:0] SU_LAST  = 8'(T_SU - 1);
  localparam logic [7:0] STB_LAST = 8'(T_STB - 1);
  localparam logic [7:0] HLD_LAST = 8'(T_HLD - 1);

  acc_state_t  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic        wr_n_q, wr_n_d;
  logic        rd_n_q, rd_n_d;
  logic [3:0]  cs_q, cs_d;
  logic [1:0]  a_q, a_d;
  logic [15:0] d_q, d_d;
  logic        doe_q, doe_d;
  logic        rvld_q, rvld_d;
  logic [15:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        load;

  assign hold_end = (state_q == AS_HOLD) && (cnt_q == HLD_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    wr_n_d  = wr_n_q;
    rd_n_d  = rd_n_q;
    cs_d    = cs_q;
    a_d     = a_q;
    d_d     = d_q;
    doe_d   = doe_q;
    rvld_d  = 1'b0;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      AS_IDLE: load = start;
      AS_SETUP: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == SU_LAST) begin
          state_d = AS_STROBE;
          cnt_d   = '0;
          wr_n_d  = ~wr_q;
          rd_n_d  = wr_q;
        end
      end
      AS_STROBE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == STB_LAST) begin
          state_d = AS_HOLD;
          cnt_d   = '0;
          wr_n_d  = 1'b1;
          rd_n_d  = 1'b1;
          if (!wr_q) begin
            rdata_d = bus.iD;
            rvld_d  = 1'b1;
          end
        end
      end
      AS_HOLD: begin
        cnt_d = cnt_q + 8'd1;
        if (hold_end) begin
          if (more) begin
            load = 1'b1;
          end else begin
            state_d = AS_IDLE;
            cnt_d   = '0;
            cs_d    = CS_IDLE;
            doe_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = AS_IDLE;
    endcase
    if (load) begin
      state_d = AS_SETUP;
      cnt_d   = '0;
      wr_d    = wr;
      a_d     = addr;
      cs_d    = CS;
      d_d     = wr ? wdata : d_q;
      doe_d   = wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= AS_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      cs_q    <= CS_IDLE;
      a_q     <= '0;
      d_q     <= '0;
      doe_q   <= 1'b0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      cs_q    <= cs_d;
      a_q     <= a_d;
      d_q     <= d_d;
      doe_q   <= doe_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  assign bus.oWr  = wr_n_q;
  assign bus.oRd  = rd_n_q;
  assign bus.oCS  = cs_q;
  assign bus.oA   = a_q;
  assign bus.oD   = d_q;
  assign bus.oDOe = doe_q;
  assign rd_vld   = rvld_q;
  assign rdata    = rdata_q;
  assign done     = done_q;

endmodule

// File: rtl/prm_bus_master.sv
// PRM relay-board bus master: sequences W0..W3, R3, R1 on request or periodic
// refresh, then verifies the password, version, enable state and command echo.
module prm_bus_master
  import prm_pkg::*;
#(
  parameter logic [3:0]  CS       = 4'b0111,
  parameter logic [3:0]  CS_IDLE  = 4'b1111,
  parameter logic [7:0]  PASSWORD = 8'hA6,
  parameter logic [5:0]  VERSION  = 6'h24,
  parameter int unsigned T_SU     = 2,
  parameter int unsigned T_STB    = 4,
  parameter int unsigned T_HLD    = 2,
  parameter int unsigned REFRESH  = 50000
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic [15:0] iCom,
  input  logic [15:0] iInd,
  input  logic        iEnReq,
  output logic        oBusy,
  output logic        oDone,
  output logic [3:0]  oErr,
  output logic        oKey,
  prm_bus_master_if.master bus
);

  localparam logic [31:0] REF_LAST = 32'(REFRESH - 1);

  step_t       step_q, step_d, nxt_step;
  logic [15:0] com_q, com_d;
  logic [15:0] ind_q, ind_d;
  logic        en_q, en_d;
  logic        go_q, go_d;
  logic        busy_q, busy_d;
  logic        pend_q, pend_d;
  logic [3:0]  err_q, err_d;
  logic        key_q, key_d;
  logic [31:0] ref_q, ref_d;

  logic        hold_end, rd_vld, more, seq_end, tick, trig, active;
  logic        ld_wr;
  logic [1:0]  ld_a;
  logic [15:0] ld_wd, rdata;

  assign more     = (step_q != S_R1);
  assign seq_end  = hold_end && !more;
  assign nxt_step = (hold_end && more) ? step_t'(step_q + 3'd1) : step_q;

  always_comb begin
    ld_wr = 1'b1;
    ld_a  = A_COM_LO;
    ld_wd = nib_enc(com_q[7:0]);
    case (nxt_step)
      S_W1: begin ld_a = A_COM_HI; ld_wd = nib_enc(com_q[15:8]); end
      S_W2: begin ld_a = A_IND;    ld_wd = ind_q; end
      S_W3: begin ld_a = A_CTRL;   ld_wd = {8'h00, en_q ? ENABLE_CODE : 8'h00}; end
      S_R3: begin ld_wr = 1'b0; ld_a = A_CTRL;   ld_wd = '0; end
      S_R1: begin ld_wr = 1'b0; ld_a = A_COM_HI; ld_wd = '0; end
      default: ;
    endcase
  end

  // A request arriving while a sequence is queued or running only arms pend_q;
  // go_q covers the one-cycle gap between the trigger and the engine leaving IDLE.
  always_comb begin
    tick   = (REFRESH != 0) && (ref_q == REF_LAST);
    trig   = iStart || tick;
    active = go_q || busy_q;
    go_d   = (!active && trig) || (seq_end && (pend_q || trig));
    pend_d = pend_q;
    if (seq_end)
      pend_d = 1'b0;
    else if (active && trig)
      pend_d = 1'b1;
    busy_d = go_q ? 1'b1 : (seq_end ? 1'b0 : busy_q);
    ref_d  = (REFRESH == 0 || go_d || tick) ? '0 : ref_q + 32'd1;
    com_d  = go_d ? iCom   : com_q;
    ind_d  = go_d ? iInd   : ind_q;
    en_d   = go_d ? iEnReq : en_q;
    step_d = seq_end ? S_W0 : nxt_step;
    err_d  = err_q;
    key_d  = key_q;
    if (go_q) begin
      err_d = '0;
    end else if (rd_vld) begin
      if (step_q == S_R3) begin
        err_d[0] = (rdata[15:8] != PASSWORD);
        err_d[1] = (rdata[7:2] != VERSION);
        err_d[2] = (rdata[0] != ~en_q);
        key_d    = rdata[1];
      end else if (step_q == S_R1) begin
        err_d[3] = (rdata != com_q);
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      step_q <= S_W0;
      com_q  <= '0;
      ind_q  <= '0;
      en_q   <= 1'b0;
      go_q   <= 1'b0;
      busy_q <= 1'b0;
      pend_q <= 1'b0;
      err_q  <= '0;
      key_q  <= 1'b0;
      ref_q  <= '0;
    end else begin
      step_q <= step_d;
      com_q  <= com_d;
      ind_q  <= ind_d;
      en_q   <= en_d;
      go_q   <= go_d;
      busy_q <= busy_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      key_q  <= key_d;
      ref_q  <= ref_d;
    end
  end

  prm_bus_cycle #(
    .CS      (CS),
    .CS_IDLE (CS_IDLE),
    .T_SU    (T_SU),
    .T_STB   (T_STB),
    .T_HLD   (T_HLD)
  ) u_cycle (
    .clk      (iClk),
    .rst      (iRst),
    .start    (go_q),
    .more     (more),
    .wr       (ld_wr),
    .addr     (ld_a),
    .wdata    (ld_wd),
    .hold_end (hold_end),
    .rd_vld   (rd_vld),
    .rdata    (rdata),
    .done     (oDone),
    .bus      (bus)
  );

  assign oBusy = busy_q;
  assign oErr  = err_q;
  assign oKey  = key_q;

endmodule
